// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle: stall requests and redirect in, per-stage holds, flush and statistics out.
// The pipeline side uses the master modport; pipe_ctrl uses the slave modport.
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             stallreq_id;
  logic             stallreq_ex;
  logic             stallreq_mem;
  logic             flush_req;
  logic [31:0]      flush_pc;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic             stall_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem, flush_req, flush_pc,
    input  stall, flush, new_pc, stall_timeout, stall_cycles
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem, flush_req, flush_pc,
    output stall, flush, new_pc, stall_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with a saturating stall statistic.
// Optional stall watchdog (counter + sticky stall_timeout) compiled in by PIPE_CTRL_WDT_EN.
module pipe_ctrl #(
  parameter int STALL_LIMIT = 16,
  parameter int CNT_W       = 16
) (
  input logic          clk,
  input logic          rst,
  pipe_ctrl_if.slave   pipe
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [5:0]       stall_req_vec;
  logic [5:0]       stall;
  logic             flush;
  logic             stalled;
  logic [31:0]      new_pc;
  logic [CNT_W-1:0] stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // A redirect always takes effect on the following cycle, from either state.
  always_comb begin
    state_next = RUN;
    case (state)
      RUN:     if (pipe.flush_req) state_next = FLUSH;
      FLUSH:   if (pipe.flush_req) state_next = FLUSH;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    stall_req_vec = 6'b000000;
    if (pipe.stallreq_mem)     stall_req_vec = 6'b011111;
    else if (pipe.stallreq_ex) stall_req_vec = 6'b001111;
    else if (pipe.stallreq_id) stall_req_vec = 6'b000111;
  end

  // flush comes straight from the state register, so it is a clean registered pulse.
  always_comb begin
    stall = 6'b000000;
    flush = 1'b0;
    case (state)
      RUN:     if (!rst) stall = stall_req_vec;
      FLUSH:   flush = 1'b1;
      default: stall = 6'b000000;
    endcase
  end

  assign stalled = (stall != 6'b000000);

  always_ff @(posedge clk) begin
    if (rst)                 new_pc <= 32'h0;
    else if (pipe.flush_req) new_pc <= pipe.flush_pc;
  end

  always_ff @(posedge clk) begin
    if (rst)                                   stall_cycles <= '0;
    else if (stalled && (stall_cycles != '1))  stall_cycles <= stall_cycles + 1'b1;
  end

`ifdef PIPE_CTRL_WDT_EN
  localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

  logic [7:0] wdt_cnt;
  logic       stall_timeout;

  always_ff @(posedge clk) begin
    if (rst)                  wdt_cnt <= 8'd0;
    else if (!stalled)        wdt_cnt <= 8'd0;
    else if (wdt_cnt != LIMIT) wdt_cnt <= wdt_cnt + 8'd1;
  end

  // Only a flush pulse (or reset) releases the sticky flag; clearing beats a fresh trip.
  always_ff @(posedge clk) begin
    if (rst)                   stall_timeout <= 1'b0;
    else if (flush)            stall_timeout <= 1'b0;
    else if (wdt_cnt == LIMIT) stall_timeout <= 1'b1;
  end

  assign pipe.stall_timeout = stall_timeout;
`else
  assign pipe.stall_timeout = 1'b0;
`endif

  assign pipe.stall        = stall;
  assign pipe.flush        = flush;
  assign pipe.new_pc       = new_pc;
  assign pipe.stall_cycles = stall_cycles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized self-checking bench for pipe_ctrl: two instances (default and narrow counter)
// share one stimulus stream and are compared against an event-level reference model.
module tb_pipe_ctrl;

  localparam int BIG_LIMIT   = 16;
  localparam int SMALL_LIMIT = 5;
  localparam int SMALL_W     = 4;
`ifdef PIPE_CTRL_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  logic r_id, r_ex, r_mem, r_fr;
  logic [31:0] r_pc;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit          m_flush;
  logic [31:0] m_pc;
  int          m_cyc;
  int          m_run;
  bit          m_to_big;
  bit          m_to_small;
  logic [5:0]  m_stall;

  pipe_ctrl_if #(.CNT_W(16))      bus_big ();
  pipe_ctrl_if #(.CNT_W(SMALL_W)) bus_small ();

  assign bus_big.stallreq_id    = r_id;
  assign bus_big.stallreq_ex    = r_ex;
  assign bus_big.stallreq_mem   = r_mem;
  assign bus_big.flush_req      = r_fr;
  assign bus_big.flush_pc       = r_pc;
  assign bus_small.stallreq_id  = r_id;
  assign bus_small.stallreq_ex  = r_ex;
  assign bus_small.stallreq_mem = r_mem;
  assign bus_small.flush_req    = r_fr;
  assign bus_small.flush_pc     = r_pc;

  pipe_ctrl #(.STALL_LIMIT(BIG_LIMIT), .CNT_W(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .pipe (bus_big)
  );

  pipe_ctrl #(.STALL_LIMIT(SMALL_LIMIT), .CNT_W(SMALL_W)) dut_small (
    .clk  (clk),
    .rst  (rst),
    .pipe (bus_small)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, actual, expected);
    end
  endtask

  // Deepest requesting stage wins; nothing holds while resetting or during a flush cycle.
  function automatic logic [5:0] refStall(input logic r, input bit fl, input logic id, input logic ex, input logic mem);
    if (r || fl) return 6'b000000;
    if (mem)     return 6'b011111;
    if (ex)      return 6'b001111;
    if (id)      return 6'b000111;
    return 6'b000000;
  endfunction

  task automatic compareModel();
    int exp_big;
    int exp_small;
    m_stall   = refStall(rst, m_flush, r_id, r_ex, r_mem);
    exp_big   = (m_cyc > 65535) ? 65535 : m_cyc;
    exp_small = (m_cyc > 15) ? 15 : m_cyc;
    checkOutput("stall",         32'(bus_big.stall),         32'(m_stall));
    checkOutput("stall_small",   32'(bus_small.stall),       32'(m_stall));
    checkOutput("flush",         32'(bus_big.flush),         32'(m_flush));
    checkOutput("flush_small",   32'(bus_small.flush),       32'(m_flush));
    checkOutput("new_pc",        bus_big.new_pc,             m_pc);
    checkOutput("cycles",        32'(bus_big.stall_cycles),  32'(exp_big));
    checkOutput("cycles_small",  32'(bus_small.stall_cycles), 32'(exp_small));
    checkOutput("timeout",       32'(bus_big.stall_timeout), 32'(WDT_ON && m_to_big));
    checkOutput("timeout_small", 32'(bus_small.stall_timeout), 32'(WDT_ON && m_to_small));
  endtask

  // Drive one cycle's inputs just after the edge, then compare mid-cycle.
  task automatic applyStimulus(input logic r, input logic id, input logic ex, input logic mem,
                               input logic fr, input logic [31:0] pc);
    rst = r; r_id = id; r_ex = ex; r_mem = mem; r_fr = fr; r_pc = pc;
    #4;
    compareModel();
  endtask

  // Advance the reference model across one rising edge.
  task automatic stepClock();
    @(posedge clk);
    if (rst) begin
      m_flush = 0; m_pc = 32'h0; m_cyc = 0; m_run = 0; m_to_big = 0; m_to_small = 0;
    end else begin
      m_to_big   = m_to_big   ? !m_flush : (m_run >= BIG_LIMIT);
      m_to_small = m_to_small ? !m_flush : (m_run >= SMALL_LIMIT);
      if (m_stall != 6'b000000) begin
        m_run++;
        m_cyc++;
      end else begin
        m_run = 0;
      end
      if (r_fr) m_pc = r_pc;
      m_flush = r_fr;
    end
    #1;
  endtask

  initial begin
    int mode;
    rst = 1'b1; r_id = 0; r_ex = 0; r_mem = 0; r_fr = 0; r_pc = 32'h0;
    m_flush = 0; m_pc = 0; m_cyc = 0; m_run = 0; m_to_big = 0; m_to_small = 0; m_stall = 0;
    @(posedge clk);
    #1;

    // reset state (a flush request during reset must be discarded)
    applyStimulus(1, 1, 1, 1, 1, 32'hDEAD_BEEF);
    checkOutput("rst_stall", 32'(bus_big.stall), 32'h0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    checkOutput("rst_flush",  32'(bus_big.flush), 32'h0);
    checkOutput("rst_new_pc", bus_big.new_pc,     32'h0);
    stepClock();

    // stage priority
    applyStimulus(0, 1, 0, 0, 0, 32'h0);
    checkOutput("prio_id", 32'(bus_big.stall), 32'h07);
    stepClock();
    applyStimulus(0, 0, 1, 0, 0, 32'h0);
    checkOutput("prio_ex", 32'(bus_big.stall), 32'h0F);
    stepClock();
    applyStimulus(0, 0, 0, 1, 0, 32'h0);
    checkOutput("prio_mem", 32'(bus_big.stall), 32'h1F);
    stepClock();
    applyStimulus(0, 1, 1, 1, 0, 32'h0);
    checkOutput("prio_all", 32'(bus_big.stall), 32'h1F);
    stepClock();

    // single flush; request cycle still stalls, flush cycle does not
    applyStimulus(0, 0, 1, 0, 1, 32'hBFC0_0380);
    checkOutput("flushreq_stall", 32'(bus_big.stall), 32'h0F);
    stepClock();
    applyStimulus(0, 0, 0, 1, 0, 32'h0);
    checkOutput("flush_pulse", 32'(bus_big.flush), 32'h1);
    checkOutput("flush_pc",    bus_big.new_pc,     32'hBFC0_0380);
    checkOutput("flush_stall", 32'(bus_big.stall), 32'h0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    checkOutput("flush_end",  32'(bus_big.flush), 32'h0);
    checkOutput("pc_hold",    bus_big.new_pc,     32'hBFC0_0380);
    stepClock();

    // back-to-back flushes
    applyStimulus(0, 0, 0, 0, 1, 32'h100);
    stepClock();
    applyStimulus(0, 0, 0, 0, 1, 32'h200);
    checkOutput("b2b_pc1", bus_big.new_pc, 32'h100);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    checkOutput("b2b_flush2", 32'(bus_big.flush), 32'h1);
    checkOutput("b2b_pc2",    bus_big.new_pc,     32'h200);
    stepClock();

    // long execute stall: watchdog trip, stickiness, counter saturation
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 1, 0, 0, 32'h0);
      stepClock();
    end
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    checkOutput("sat_small", 32'(bus_small.stall_cycles), 32'hF);
    checkOutput("wdt_sticky", 32'(bus_big.stall_timeout), 32'(WDT_ON));
    stepClock();
    applyStimulus(0, 0, 0, 0, 1, 32'h400);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    checkOutput("wdt_in_flush", 32'(bus_big.stall_timeout), 32'(WDT_ON));
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    checkOutput("wdt_cleared", 32'(bus_big.stall_timeout), 32'h0);
    stepClock();

    // reset during the flush cycle aborts the pulse and clears statistics
    applyStimulus(0, 0, 0, 0, 1, 32'h800);
    stepClock();
    applyStimulus(1, 0, 1, 0, 1, 32'h900);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    checkOutput("rstfl_flush",  32'(bus_big.flush),        32'h0);
    checkOutput("rstfl_pc",     bus_big.new_pc,            32'h0);
    checkOutput("rstfl_cycles", 32'(bus_big.stall_cycles), 32'h0);
    stepClock();

    // randomized traffic, alternating dense-stall and flush-heavy phases
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      logic id, ex, mem, fr, r;
      if (c % 60 == 0) mode = int'($urandom_range(0, 1));
      if (mode == 0) begin
        id  = ($urandom_range(0, 99) < 70);
        ex  = ($urandom_range(0, 99) < 50);
        mem = ($urandom_range(0, 99) < 30);
        fr  = ($urandom_range(0, 99) < 2);
      end else begin
        id  = ($urandom_range(0, 99) < 30);
        ex  = ($urandom_range(0, 99) < 20);
        mem = ($urandom_range(0, 99) < 10);
        fr  = ($urandom_range(0, 99) < 15);
      end
      r = ($urandom_range(0, 199) == 0);
      applyStimulus(r, id, ex, mem, fr, $urandom);
      stepClock();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
